// File: rtl/rv32i_wb_regfile.sv
// rtl/rv32i_wb_regfile.sv - RV32I writeback stage: source select, 32x32 register file, forwarding, retire/halt.
// Optional retire counter output instret when RV32I_INSTRET_EN is defined.
module rv32i_wb_regfile #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] HALT_IW  = 32'h0010_0073
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc_in,
    input  logic [31:0] iw_in,
    input  logic [31:0] alu_in,
    input  logic [4:0]  wb_reg_in,
    input  logic        wb_en_in,
    input  logic [1:0]  src_sel_in,
    input  logic [31:0] memif_rdata_in,
    input  logic [31:0] io_rdata,
    input  logic [4:0]  rs1_reg,
    input  logic [4:0]  rs2_reg,
    output logic [31:0] rs1_data,
    output logic [31:0] rs2_data,
    output logic        df_wb_enable,
    output logic [4:0]  df_wb_reg,
    output logic [31:0] df_wb_data,
    output logic        retire,
    output logic [31:0] retire_pc,
`ifdef RV32I_INSTRET_EN
    output logic [63:0] instret,
`endif
    output logic        halted
);

    typedef enum logic {RUN, HALT} state_t;

    state_t      state_q, state_d;
    logic [31:0] regs [0:31];
    logic [31:0] wb_data;
    logic        wr_fire;
    logic        retire_cond;

    always_comb begin
        wb_data = 32'h0;
        case (src_sel_in)
            2'd0:    wb_data = memif_rdata_in;
            2'd1:    wb_data = io_rdata;
            2'd2:    wb_data = alu_in;
            default: wb_data = 32'h0;
        endcase
    end

    assign halted      = (state_q == HALT);
    assign wr_fire     = wb_en_in && (wb_reg_in != 5'd0) && !halted;
    assign retire_cond = (iw_in != 32'h0) && !halted;

    assign df_wb_enable = wr_fire;
    assign df_wb_reg    = wb_reg_in;
    assign df_wb_data   = wb_data;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 32; i++) regs[i] <= 32'h0;
        end else if (wr_fire) begin
            regs[wb_reg_in] <= wb_data;
        end
    end

    // x0 is forced to zero on read; the bypass covers a same-cycle write.
    always_comb begin
        rs1_data = 32'h0;
        rs2_data = 32'h0;
        if (rs1_reg != 5'd0)
            rs1_data = (wr_fire && rs1_reg == wb_reg_in) ? wb_data : regs[rs1_reg];
        if (rs2_reg != 5'd0)
            rs2_data = (wr_fire && rs2_reg == wb_reg_in) ? wb_data : regs[rs2_reg];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= RUN;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN:     if (retire_cond && iw_in == HALT_IW) state_d = HALT;
            default: state_d = HALT;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            retire    <= 1'b0;
            retire_pc <= RESET_PC;
        end else begin
            retire <= retire_cond;
            if (retire_cond) retire_pc <= pc_in;
        end
    end

`ifdef RV32I_INSTRET_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)           instret <= 64'h0;
        else if (retire_cond) instret <= instret + 64'd1;
    end
`endif

endmodule

// File: doc/rv32i_wb_regfile.md
Name: rv32i_wb_regfile

Overview:
- Writeback stage of the 5-stage RV32I pipeline, directly downstream of the memory stage.
- Consumes the registered memory-stage outputs, selects the writeback source and writes the 32x32 register file.
- Serves two combinational register read ports to the decode stage, with write-through bypass.
- Exports writeback-stage forwarding, retire pulse, sticky halt status and an optional retire counter.

Parameters:
- RESET_PC, 32'h0000_0000, value driven on retire_pc during reset.
- HALT_IW, 32'h0010_0073, instruction word (EBREAK) that halts retirement.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- pc_in  in  32  PC of instruction in writeback
- iw_in  in  32  instruction word; 32'h0 marks a bubble
- alu_in  in  32  ALU result
- wb_reg_in  in  5  destination register
- wb_en_in  in  1  register write request
- src_sel_in  in  2  writeback source select: 0 mem, 1 io, 2 alu, 3 reserved
- memif_rdata_in  in  32  formatted load data from memory stage
- io_rdata  in  32  IO read data
- rs1_reg  in  5  decode read address A
- rs2_reg  in  5  decode read address B
- rs1_data  out  32  read data A
- rs2_data  out  32  read data B
- df_wb_enable  out  1  forwarding valid
- df_wb_reg  out  5  forwarding register
- df_wb_data  out  32  forwarding data
- retire  out  1  one-cycle pulse per retired instruction
- retire_pc  out  32  PC of last retired instruction
- halted  out  1  sticky halt flag

Behaviour:
- wb_data is combinational:
  - src_sel 0 -> memif_rdata_in
  - src_sel 1 -> io_rdata
  - src_sel 2 -> alu_in
  - src_sel 3 -> 32'h0
- wr_fire = wb_en_in && (wb_reg_in != 0) && !halted.
- On posedge clk, when wr_fire, regs[wb_reg_in] <= wb_data.
- x0 is never written and always reads 0.
- Read ports are combinational. If rsN_reg == wb_reg_in, wr_fire is high and rsN_reg != 0, rsN_data = wb_data (write-through bypass). Otherwise rsN_data = regs[rsN_reg].
- Forwarding outputs:
  - df_wb_enable = wr_fire.
  - df_wb_reg = wb_reg_in.
  - df_wb_data = wb_data.
  - All combinational, zero latency.
- Retire condition: iw_in != 0 && !halted.
  - retire is registered, asserted the cycle after the instruction is present.
  - retire_pc is registered and updated on the retiring instruction only.
- Halt state machine, states RUN and HALT:
  - RUN -> HALT when iw_in == HALT_IW and retire condition holds. The EBREAK itself retires (retire pulses once).
  - HALT blocks all later register writes and retires.
  - HALT exits only on reset. halted = (state == HALT).
- Reset (reset low, asynchronous):
  - All 32 registers cleared to 0.
  - state = RUN; retire = 0; retire_pc = RESET_PC.
  - halted = 0 (derived from state).
  - Reset mid-write discards the write.
- Simultaneous write and read of the same register: bypass value is returned.
- Write with wb_en_in = 0 or wb_reg_in = 0: no state change, df_wb_enable = 0.
- Bubbles (iw_in = 0) with wb_en_in = 1 still write. The memory stage guarantees wb_en = 0 on bubbles.

Optional Feature:
- Macro: RV32I_INSTRET_EN.
- Defined:
  - Adds 64-bit output instret, reset to 0.
  - instret increments by 1 each cycle the retire condition holds, wrapping from 2^64-1 to 0.
  - instret freezes in HALT.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
- Reset low mid-run with x5 = 32'hDEAD_BEEF -> rs1_data for x5 reads 0 immediately, halted = 0, retire_pc = RESET_PC.
- wb_en = 1, reg 7, src_sel 2, alu 32'h1234 while rs1_reg = 7 -> rs1_data = 32'h1234 the same cycle; after the edge it still reads 32'h1234 with wb_en = 0.
- Write to x0 with alu 32'hFFFF_FFFF -> df_wb_enable = 0, x0 reads 0.
- src_sel 0 / 1 / 3 with mem 32'hAA, io 32'hBB into x3 -> x3 reads 32'hAA, then 32'hBB, then 0 on successive writes.
- EBREAK at pc 32'h40, then an addi to x4 -> retire pulses once with retire_pc = 32'h40, halted = 1, x4 unchanged, no further retire pulses.
- With RV32I_INSTRET_EN: 10 valid instructions, 3 bubbles, then EBREAK -> instret = 11, stays 11 afterwards.
